// File: rtl/costas_ctrl_pkg.sv
// Shared types and default constants for the Costas loop acquisition controller.
package costas_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StAcq   = 2'd1,
    StPull  = 2'd2,
    StTrack = 2'd3
  } acq_state_e;

  localparam int unsigned DefAcqShift  = 4;
  localparam int unsigned DefMidShift  = 6;
  localparam int unsigned DefTrkShift  = 8;
  localparam int unsigned DefLockCnt   = 4;
  localparam int unsigned DefUnlockCnt = 2;

  // Width of the good/bad window counters; lock counts must fit.
  localparam int unsigned CntW = 8;

  // Increment that holds at the limit instead of wrapping.
  function automatic logic [CntW-1:0] sat_inc(input logic [CntW-1:0] cnt,
                                               input int unsigned     lim);
    if (32'(cnt) >= lim) begin
      return cnt;
    end
    return cnt + 1'b1;
  endfunction

endpackage

// File: rtl/costas_win_accum.sv
// Sums |pd| over 2^WIN_LOG2 valid samples and registers the window mean.
module costas_win_accum #(
  parameter int unsigned PD_W     = 17,
  parameter int unsigned WIN_LOG2 = 10
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   en_i,
  input  logic                   clr_i,
  input  logic signed [PD_W-1:0] pd_i,
  input  logic                   pd_valid_i,
  output logic                   done_o,
  output logic [PD_W-1:0]        mean_o,
  output logic [PD_W-1:0]        win_err_o,
  output logic                   win_err_valid_o
);

  localparam int unsigned SumW = PD_W + WIN_LOG2;

  logic [PD_W-1:0]     mag;
  logic [SumW-1:0]     sum_q, sum_d, sum_next;
  logic [WIN_LOG2-1:0] cnt_q, cnt_d;
  logic [PD_W-1:0]     win_err_q;
  logic                win_err_valid_q;
  logic                accept;

  // Most negative input maps to 2^(PD_W-1) as an unsigned magnitude.
  assign mag      = pd_i[PD_W-1] ? (~pd_i + 1'b1) : pd_i;
  assign sum_next = sum_q + SumW'(mag);
  assign accept   = en_i && pd_valid_i;
  assign done_o   = accept && (cnt_q == '1);
  assign mean_o   = sum_next[SumW-1:WIN_LOG2];

  always_comb begin
    sum_d = sum_q;
    cnt_d = cnt_q;
    if (clr_i || done_o) begin
      sum_d = '0;
      cnt_d = '0;
    end else if (accept) begin
      sum_d = sum_next;
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sum_q           <= '0;
      cnt_q           <= '0;
      win_err_q       <= '0;
      win_err_valid_q <= 1'b0;
    end else begin
      sum_q           <= sum_d;
      cnt_q           <= cnt_d;
      win_err_valid_q <= done_o;
      if (done_o) begin
        win_err_q <= mean_o;
      end
    end
  end

  assign win_err_o       = win_err_q;
  assign win_err_valid_o = win_err_valid_q;

endmodule

// File: rtl/costas_acq_ctrl.sv
// Costas loop acquisition controller: windowed |pd| drives IDLE/ACQ/PULL/TRACK
// and selects the loop-gain shift.
module costas_acq_ctrl
  import costas_ctrl_pkg::*;
#(
  parameter int unsigned PD_W       = 17,
  parameter int unsigned WIN_LOG2   = 10,
  parameter int unsigned ACQ_SHIFT  = DefAcqShift,
  parameter int unsigned MID_SHIFT  = DefMidShift,
  parameter int unsigned TRK_SHIFT  = DefTrkShift,
  parameter int unsigned LOCK_CNT   = DefLockCnt,
  parameter int unsigned UNLOCK_CNT = DefUnlockCnt
) (
  input  logic                   aclk,
  input  logic                   areset,
  input  logic                   enable,
  input  logic signed [PD_W-1:0] pd_tdata,
  input  logic                   pd_tvalid,
  input  logic [15:0]            lock_thresh,
  input  logic [15:0]            unlock_thresh,
  output logic [3:0]             gain_shift,
  output logic                   pacc_clear,
  output logic                   locked,
  output logic [1:0]             state,
  output logic [PD_W-1:0]        win_err_tdata,
  output logic                   win_err_tvalid
);

  acq_state_e      state_q, state_d;
  logic [CntW-1:0] good_cnt_q, good_cnt_d, bad_cnt_q, bad_cnt_d;
  logic [CntW-1:0] good_inc, bad_inc;
  logic [3:0]      gain_shift_q, gain_shift_d;
  logic            locked_q, locked_d, pacc_clear_q, pacc_clear_d;
  logic            win_done, win_en, win_clr, is_good, is_bad;
  logic [PD_W-1:0] win_mean;

  assign win_en   = (state_q != StIdle);
  assign is_good  = win_mean < PD_W'(lock_thresh);
  assign is_bad   = win_mean > PD_W'(unlock_thresh);
  assign good_inc = sat_inc(good_cnt_q, LOCK_CNT);
  assign bad_inc  = sat_inc(bad_cnt_q, UNLOCK_CNT);

  costas_win_accum #(
    .PD_W     (PD_W),
    .WIN_LOG2 (WIN_LOG2)
  ) u_win_accum (
    .clk_i           (aclk),
    .rst_i           (areset),
    .en_i            (win_en),
    .clr_i           (win_clr),
    .pd_i            (pd_tdata),
    .pd_valid_i      (pd_tvalid),
    .done_o          (win_done),
    .mean_o          (win_mean),
    .win_err_o       (win_err_tdata),
    .win_err_valid_o (win_err_tvalid)
  );

  always_comb begin
    state_d      = state_q;
    good_cnt_d   = good_cnt_q;
    bad_cnt_d    = bad_cnt_q;
    pacc_clear_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        good_cnt_d = '0;
        bad_cnt_d  = '0;
        if (enable) begin
          state_d      = StAcq;
          pacc_clear_d = 1'b1;
        end
      end
      StAcq: begin
        if (win_done) begin
          if (!is_good) begin
            good_cnt_d = '0;
          end else if (good_inc == CntW'(LOCK_CNT)) begin
            state_d    = StPull;
            good_cnt_d = '0;
          end else begin
            good_cnt_d = good_inc;
          end
        end
      end
      StPull: begin
        if (win_done) begin
          if (!is_good) begin
            state_d    = StAcq;
            good_cnt_d = '0;
          end else if (good_inc == CntW'(LOCK_CNT)) begin
            state_d    = StTrack;
            good_cnt_d = '0;
            bad_cnt_d  = '0;
          end else begin
            good_cnt_d = good_inc;
          end
        end
      end
      StTrack: begin
        if (win_done) begin
          if (!is_bad) begin
            bad_cnt_d = '0;
          end else if (bad_inc == CntW'(UNLOCK_CNT)) begin
            state_d      = StAcq;
            pacc_clear_d = 1'b1;
            good_cnt_d   = '0;
            bad_cnt_d    = '0;
          end else begin
            bad_cnt_d = bad_inc;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Dropping enable overrides any window-end transition in the same cycle.
    if (!enable && (state_q != StIdle)) begin
      state_d      = StIdle;
      good_cnt_d   = '0;
      bad_cnt_d    = '0;
      pacc_clear_d = 1'b0;
    end

    unique case (state_d)
      StPull:  gain_shift_d = 4'(MID_SHIFT);
      StTrack: gain_shift_d = 4'(TRK_SHIFT);
      default: gain_shift_d = 4'(ACQ_SHIFT);
    endcase
    locked_d = (state_d == StTrack);
    win_clr  = (state_q == StIdle) || (state_d != state_q);
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q      <= StIdle;
      good_cnt_q   <= '0;
      bad_cnt_q    <= '0;
      gain_shift_q <= 4'(ACQ_SHIFT);
      locked_q     <= 1'b0;
      pacc_clear_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      good_cnt_q   <= good_cnt_d;
      bad_cnt_q    <= bad_cnt_d;
      gain_shift_q <= gain_shift_d;
      locked_q     <= locked_d;
      pacc_clear_q <= pacc_clear_d;
    end
  end

  assign state      = state_q;
  assign gain_shift = gain_shift_q;
  assign locked     = locked_q;
  assign pacc_clear = pacc_clear_q;

endmodule
